cm_arb_stream: RTL and testbench

- Parametrised N-way stream arbiter with a packet-locked multiplexer. It is the sequential successor to the bare arbiter algorithms in cm_pkg.
- Selects one of N valid/ready input channels using a compile-time algorithm: fixed-min, fixed-max or round-robin.
- Holds the grant until the beat carrying last is accepted, then forwards data, last and source index downstream.
- Used wherever several producers share one stream sink, such as bus masters or DMA channels.

---
 rtl/cm_pkg.sv | 52 +++++
 rtl/cm_arb_pick.sv | 60 ++++++
 rtl/cm_arb_stream.sv | 144 ++++++++++++++
 tb/tb_cm_arb_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// ----------------------------------------------------------------------------
// cm_pkg
// Shared arbitration types and helpers.
//   t_arb_algo   : arbitration algorithm selector (fixed-min, fixed-max,
//                  round-robin).
//   t_arb_state  : lock state of a packet-aware stream arbiter.
//   arb_rr_pick  : rotating-priority pick over up to ARB_MAX_N requesters,
//                  reusable by any arbiter that keeps a start pointer.
// ----------------------------------------------------------------------------
package cm_pkg;

   typedef enum logic [1:0] {
      ARB_MIN = 2'd0,
      ARB_MAX = 2'd1,
      ARB_RR  = 2'd2
   } t_arb_algo;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } t_arb_state;

   localparam int ARB_MAX_N = 32;

   // First set bit of req at or after ptr, wrapping modulo n. Callers pad req
   // and ptr to the full width; bits at or above n are never looked at.
   // Returns 0 when req is empty (the caller qualifies with |req).
   function automatic logic [4:0] arb_rr_pick(input logic [31:0] req,
                                              input logic [4:0]  ptr,
                                              input int unsigned n);
      logic [4:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
         if (i < n) begin
            idx = {27'd0, ptr} + i;
            // explicit compare-and-wrap: n need not be a power of two
            if (idx >= n) begin
               idx = idx - n;
            end
            if (!found && req[idx[4:0]]) begin
               found = 1'b1;
               pick  = idx[4:0];
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cm_arb_pick.sv
// ----------------------------------------------------------------------------
// cm_arb_pick
// Combinational winner selector.
//   i_req    [N]      request vector
//   i_ptr    [IDX_W]  round-robin start pointer (ignored by MIN/MAX)
//   o_winner [IDX_W]  granted index (0 when no request)
//   o_valid           at least one request present
// ----------------------------------------------------------------------------
module cm_arb_pick
   import cm_pkg::*;
#(
   parameter  int        N     = 4,
   parameter  t_arb_algo ALGO  = ARB_RR,
   localparam int        IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   logic [31:0] w_req_pad;
   logic [4:0]  w_ptr_pad;
   logic [4:0]  w_rr_pick;

   always_comb begin
      w_req_pad              = '0;
      w_req_pad[N-1:0]       = i_req;
      w_ptr_pad              = '0;
      w_ptr_pad[IDX_W-1:0]   = i_ptr;
      w_rr_pick              = arb_rr_pick(w_req_pad, w_ptr_pad, N);
   end

   always_comb begin
      o_winner = '0;
      case (ALGO)
         ARB_MIN: begin
            // scan downward so the lowest set index is assigned last
            for (int k = N - 1; k >= 0; k--) begin
               if (i_req[k]) begin
                  o_winner = IDX_W'(k);
               end
            end
         end
         ARB_MAX: begin
            for (int k = 0; k < N; k++) begin
               if (i_req[k]) begin
                  o_winner = IDX_W'(k);
               end
            end
         end
         default: begin
            o_winner = IDX_W'(w_rr_pick);
         end
      endcase
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/cm_arb_stream.sv
// ----------------------------------------------------------------------------
// cm_arb_stream
// N-way valid/ready stream arbiter with a packet-locked multiplexer.
// A channel that wins arbitration keeps the grant until its last beat is
// accepted downstream. Input to output is purely combinational.
//   clk, rst_n            clock / asynchronous active-low reset
//   i_mask   [N]          per-channel enable for new arbitration
//   i_valid  [N]          per-channel valid
//   i_last   [N]          per-channel end-of-packet
//   i_data   [N*W]        channel k at [k*W +: W]
//   o_ready  [N]          per-channel ready (at most one set)
//   o_valid, o_last       forwarded handshake
//   o_data   [W]          forwarded data
//   o_idx    [IDX_W]      source channel of the forwarded beat
//   i_ready               downstream ready
//   o_locked              a packet is in progress
// ----------------------------------------------------------------------------
module cm_arb_stream
   import cm_pkg::*;
#(
   parameter  int        N     = 4,
   parameter  int        W     = 32,
   parameter  t_arb_algo ALGO  = ARB_RR,
   localparam int        IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     i_mask,
   input  logic [N-1:0]     i_valid,
   input  logic [N-1:0]     i_last,
   input  logic [N*W-1:0]   i_data,
   output logic [N-1:0]     o_ready,
   output logic             o_valid,
   output logic             o_last,
   output logic [W-1:0]     o_data,
   output logic [IDX_W-1:0] o_idx,
   input  logic             i_ready,
   output logic             o_locked
);

   t_arb_state       r_state;
   logic [IDX_W-1:0] r_gnt;
   logic [IDX_W-1:0] r_rr_ptr;

   logic [N-1:0]     w_req;
   logic [IDX_W-1:0] w_winner;
   logic             w_win_valid;
   logic [IDX_W-1:0] w_sel;
   logic             w_ch_valid;
   logic             w_locked;
   logic             w_accept;

   function automatic logic [IDX_W-1:0] f_wrap_inc(input logic [IDX_W-1:0] x);
      return (x == IDX_W'(N - 1)) ? '0 : x + IDX_W'(1);
   endfunction

   assign w_req    = i_valid & i_mask;
   assign w_locked = (r_state == ARB_LOCKED);

   cm_arb_pick #(
      .N    (N),
      .ALGO (ALGO)
   ) u_pick (
      .i_req    (w_req),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_winner),
      .o_valid  (w_win_valid)
   );

   // The mask only gates new arbitration; once locked the granted channel is
   // followed regardless of i_mask.
   assign w_sel = w_locked ? r_gnt : w_winner;

   always_comb begin
      o_data     = '0;
      o_last     = 1'b0;
      w_ch_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (IDX_W'(k) == w_sel) begin
            o_data     = i_data[k*W +: W];
            o_last     = i_last[k];
            w_ch_valid = i_valid[k];
         end
      end
   end

   assign o_valid  = w_locked ? w_ch_valid : w_win_valid;
   assign o_idx    = w_sel;
   assign o_locked = w_locked;
   assign w_accept = o_valid && i_ready && o_last;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ready
         assign o_ready[gi] = i_ready && (w_sel == IDX_W'(gi)) && o_valid;
      end
   endgenerate

   // Any granted beat that is not a completed single-beat packet locks, so a
   // stalled beat cannot have its source swapped underneath it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ARB_IDLE;
         r_gnt    <= '0;
         r_rr_ptr <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_win_valid) begin
                  if (w_accept) begin
                     if (ALGO == ARB_RR) begin
                        r_rr_ptr <= f_wrap_inc(w_winner);
                     end
                  end else begin
                     r_state <= ARB_LOCKED;
                     r_gnt   <= w_winner;
                  end
               end
            end
            ARB_LOCKED: begin
               if (w_accept) begin
                  r_state <= ARB_IDLE;
                  if (ALGO == ARB_RR) begin
                     r_rr_ptr <= f_wrap_inc(r_gnt);
                  end
               end
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

   a_gnt_range : assert property (@(posedge clk) disable iff (!rst_n)
      int'(r_gnt) < N);

   a_idx_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (w_locked && !w_accept) |=> (o_idx == $past(o_idx)));

   a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(o_ready));

endmodule

// File: tb/tb_cm_arb_stream.sv
// ----------------------------------------------------------------------------
// tb_cm_arb_stream
// Three arbiters (RR, MAX, MIN; N=4, W=32) driven by directed vectors.
// Expected beats are queued per instance as stimulus is issued; a monitor
// pops and compares on every accepted beat (o_valid && i_ready).
// ----------------------------------------------------------------------------
module tb_cm_arb_stream;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  mask  [3];
   logic [3:0]  valid [3];
   logic [3:0]  last  [3];
   logic [127:0] data [3];
   logic        rdy   [3];
   logic [3:0]  ordy  [3];
   logic        ov    [3];
   logic        olast [3];
   logic        olock [3];
   logic [31:0] odata [3];
   logic [1:0]  oidx  [3];

   exp_t exp_q [3][$];
   int   n_checks = 0;
   int   n_err    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cm_arb_stream #(.N(4), .W(32), .ALGO(cm_pkg::ARB_RR)) u_rr (
      .clk(clk), .rst_n(rst_n), .i_mask(mask[0]), .i_valid(valid[0]),
      .i_last(last[0]), .i_data(data[0]), .o_ready(ordy[0]), .o_valid(ov[0]),
      .o_last(olast[0]), .o_data(odata[0]), .o_idx(oidx[0]),
      .i_ready(rdy[0]), .o_locked(olock[0]));

   cm_arb_stream #(.N(4), .W(32), .ALGO(cm_pkg::ARB_MAX)) u_max (
      .clk(clk), .rst_n(rst_n), .i_mask(mask[1]), .i_valid(valid[1]),
      .i_last(last[1]), .i_data(data[1]), .o_ready(ordy[1]), .o_valid(ov[1]),
      .o_last(olast[1]), .o_data(odata[1]), .o_idx(oidx[1]),
      .i_ready(rdy[1]), .o_locked(olock[1]));

   cm_arb_stream #(.N(4), .W(32), .ALGO(cm_pkg::ARB_MIN)) u_min (
      .clk(clk), .rst_n(rst_n), .i_mask(mask[2]), .i_valid(valid[2]),
      .i_last(last[2]), .i_data(data[2]), .o_ready(ordy[2]), .o_valid(ov[2]),
      .o_last(olast[2]), .o_data(odata[2]), .o_idx(oidx[2]),
      .i_ready(rdy[2]), .o_locked(olock[2]));

   function automatic void chk(input string nm, input logic [63:0] got,
                               input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic [3:0] v, input logic [3:0] l,
                        input logic r);
      valid[d] = v;
      last[d]  = l;
      rdy[d]   = r;
   endtask

   task automatic set_ch(input int d, input int ch, input logic [31:0] val);
      data[d][ch*32 +: 32] = val;
   endtask

   task automatic push(input int d, input int idx, input logic [31:0] dv,
                       input logic lv);
      exp_t e;
      e.idx  = 2'(idx);
      e.data = dv;
      e.last = lv;
      exp_q[d].push_back(e);
   endtask

   // monitor: one line per accepted beat
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (ov[d] && rdy[d]) begin
               $display("beat dut%0d idx=%0d data=0x%08h last=%0b",
                        d, oidx[d], odata[d], olast[d]);
               if (exp_q[d].size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL beat_unexpected dut%0d: got idx=%0d data=0x%0h, expected no beat",
                           d, oidx[d], odata[d]);
               end else begin
                  exp_t e;
                  e = exp_q[d].pop_front();
                  chk($sformatf("beat dut%0d {idx,data,last}", d),
                      {29'd0, oidx[d], odata[d], olast[d]},
                      {29'd0, e.idx, e.data, e.last});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         mask[d] = 4'hF;
         drive(d, 4'h0, 4'h0, 1'b0);
         data[d] = '0;
      end

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset o_valid dut%0d", d), 64'(ov[d]), 64'd0);
         chk($sformatf("reset o_locked dut%0d", d), 64'(olock[d]), 64'd0);
         chk($sformatf("reset o_ready dut%0d", d), 64'(ordy[d]), 64'd0);
      end
      rst_n = 1'b1;
      tick();

      // RR: continuous single-beat packets from all channels
      for (int k = 0; k < 4; k++) set_ch(0, k, 32'h100 + k);
      drive(0, 4'b1111, 4'b1111, 1'b1);
      push(0, 0, 32'h100, 1'b1);
      push(0, 1, 32'h101, 1'b1);
      push(0, 2, 32'h102, 1'b1);
      push(0, 3, 32'h103, 1'b1);
      push(0, 0, 32'h100, 1'b1);
      push(0, 1, 32'h101, 1'b1);
      repeat (6) tick();
      drive(0, 4'b0000, 4'b0000, 1'b1);
      tick();                                   // rr_ptr = 2

      // RR: 3-beat packet on ch2 while ch0/ch3 request
      set_ch(0, 0, 32'hC0);
      set_ch(0, 3, 32'hD3);
      set_ch(0, 2, 32'hA0);
      drive(0, 4'b0100, 4'b0000, 1'b1);
      push(0, 2, 32'hA0, 1'b0);
      push(0, 2, 32'hA1, 1'b0);
      push(0, 2, 32'hA2, 1'b1);
      push(0, 3, 32'hD3, 1'b1);
      push(0, 0, 32'hC0, 1'b1);
      @(negedge clk);
      chk("pkt first beat o_locked", 64'(olock[0]), 64'd0);
      tick();
      set_ch(0, 2, 32'hA1);
      drive(0, 4'b1101, 4'b1001, 1'b1);
      @(negedge clk);
      chk("pkt beat1 o_locked", 64'(olock[0]), 64'd1);
      chk("pkt beat1 o_ready", 64'(ordy[0]), 64'b0100);
      tick();
      set_ch(0, 2, 32'hA2);
      last[0] = 4'b1101;
      @(negedge clk);
      chk("pkt beat2 o_locked", 64'(olock[0]), 64'd1);
      tick();
      drive(0, 4'b1001, 4'b1001, 1'b1);
      @(negedge clk);
      chk("after pkt o_locked", 64'(olock[0]), 64'd0);
      tick();
      tick();                                   // ch0 served, rr_ptr = 1
      drive(0, 4'b0000, 4'b0000, 1'b1);
      tick();

      // RR mask: bring rr_ptr to 2, then mask ch2 with all valid
      for (int k = 0; k < 4; k++) set_ch(0, k, 32'h500 + k);
      drive(0, 4'b0010, 4'b0010, 1'b1);
      push(0, 1, 32'h501, 1'b1);
      tick();                                   // rr_ptr = 2
      mask[0] = 4'b1011;
      drive(0, 4'b1111, 4'b1111, 1'b1);
      push(0, 3, 32'h503, 1'b1);
      push(0, 0, 32'h500, 1'b1);
      push(0, 1, 32'h501, 1'b1);
      push(0, 3, 32'h503, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("masked ch2 o_ready[2] cyc%0d", c), 64'(ordy[0][2]), 64'd0);
         tick();
      end
      // mask applied mid-packet: ch2 must finish its packet
      mask[0] = 4'b1111;
      set_ch(0, 2, 32'hE0);
      drive(0, 4'b0100, 4'b0000, 1'b1);
      push(0, 2, 32'hE0, 1'b0);
      push(0, 2, 32'hE1, 1'b0);
      push(0, 2, 32'hE2, 1'b1);
      tick();
      mask[0] = 4'b1011;
      set_ch(0, 2, 32'hE1);
      drive(0, 4'b1111, 4'b1011, 1'b1);
      @(negedge clk);
      chk("mid-pkt mask o_ready", 64'(ordy[0]), 64'b0100);
      tick();
      set_ch(0, 2, 32'hE2);
      last[0] = 4'b1111;
      tick();                                   // rr_ptr = 3
      mask[0] = 4'b1111;
      drive(0, 4'b0000, 4'b0000, 1'b1);
      tick();

      // MAX: 5-cycle stall, ch0 raises valid mid-stall
      set_ch(1, 0, 32'h300);
      set_ch(1, 1, 32'h311);
      drive(1, 4'b0010, 4'b1111, 1'b0);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) valid[1] = 4'b0011;
         @(negedge clk);
         chk($sformatf("stall o_idx cyc%0d", c), 64'(oidx[1]), 64'd1);
         chk($sformatf("stall o_data cyc%0d", c), 64'(odata[1]), 64'h311);
         chk($sformatf("stall o_valid cyc%0d", c), 64'(ov[1]), 64'd1);
         chk($sformatf("stall o_ready cyc%0d", c), 64'(ordy[1]), 64'd0);
         tick();
      end
      rdy[1] = 1'b1;
      push(1, 1, 32'h311, 1'b1);
      push(1, 1, 32'h311, 1'b1);
      push(1, 0, 32'h300, 1'b1);
      tick();
      tick();
      valid[1] = 4'b0001;
      tick();
      valid[1] = 4'b0000;
      tick();

      // MIN vs MAX, one cycle with req = 0110
      for (int d = 1; d < 3; d++) begin
         set_ch(d, 1, 32'h401);
         set_ch(d, 2, 32'h402);
         drive(d, 4'b0110, 4'b0110, 1'b1);
      end
      push(1, 2, 32'h402, 1'b1);
      push(2, 1, 32'h401, 1'b1);
      tick();
      drive(1, 4'b0000, 4'b0000, 1'b1);
      drive(2, 4'b0000, 4'b0000, 1'b1);
      tick();

      // RR: asynchronous reset in the middle of a packet
      set_ch(0, 1, 32'hF0);
      drive(0, 4'b0010, 4'b0000, 1'b1);
      push(0, 1, 32'hF0, 1'b0);
      @(negedge clk);
      chk("pre-reset o_locked idle", 64'(olock[0]), 64'd0);
      tick();
      set_ch(0, 1, 32'hF1);
      rdy[0] = 1'b0;
      @(negedge clk);
      chk("pre-reset o_locked", 64'(olock[0]), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset o_locked", 64'(olock[0]), 64'd0);
      drive(0, 4'b0000, 4'b0000, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) set_ch(0, k, 32'h600 + k);
      drive(0, 4'b1111, 4'b1111, 1'b1);
      push(0, 0, 32'h600, 1'b1);
      push(0, 1, 32'h601, 1'b1);
      @(negedge clk);
      chk("post-reset first o_idx", 64'(oidx[0]), 64'd0);
      tick();
      tick();
      drive(0, 4'b0000, 4'b0000, 1'b1);
      repeat (3) tick();

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("leftover expected beats dut%0d", d), 64'(exp_q[d].size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
